// File: rtl/writeback_stage.sv
// MEM/WB writeback stage: selects the writeback source, aligns and extends load data,
// and holds off upstream while a load response is outstanding.
module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            wb_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc_plus_4,
  input  logic [XLEN-1:0]       pc_plus_imm,
  input  logic [XLEN-1:0]       imm,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            addr_low,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  misalign_err,
  output logic                  spurious_err
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [2:0] SEL_ALU   = 3'b000;
  localparam logic [2:0] SEL_MEM   = 3'b001;
  localparam logic [2:0] SEL_PC4   = 3'b010;
  localparam logic [2:0] SEL_PCIMM = 3'b011;
  localparam logic [2:0] SEL_IMM   = 3'b100;

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic [1:0]            load_size_q, load_size_d;
  logic                  load_unsigned_q, load_unsigned_d;
  logic [1:0]            addr_low_q, addr_low_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  misalign_q, misalign_d;
  logic                  spurious_q, spurious_d;

  // Pick the lane addressed by addr_low and widen it to XLEN.
  function automatic logic [XLEN-1:0] extend_load(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  addr
  );
    logic [XLEN-1:0] res;
    logic [7:0]      b;
    logic [15:0]     h;
    b = 8'(word >> {addr, 3'b000});
    h = 16'(word >> {addr[1], 4'b0000});
    case (size)
      2'b00: begin
        res      = {XLEN{b[7] & ~uns}};
        res[7:0] = b;
      end
      2'b01: begin
        res       = {XLEN{h[15] & ~uns}};
        res[15:0] = h;
      end
      default: begin
        res       = {XLEN{word[31] & ~uns}};
        res[31:0] = word;
      end
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr[0];
      default: return addr != 2'b00;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] select_src(input logic [2:0] sel);
    case (sel)
      SEL_PC4:   return pc_plus_4;
      SEL_PCIMM: return pc_plus_imm;
      SEL_IMM:   return imm;
      default:   return alu_result;
    endcase
  endfunction

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    reg_write_d     = reg_write_q;
    load_size_d     = load_size_q;
    load_unsigned_d = load_unsigned_q;
    addr_low_d      = addr_low_q;
    rf_we_d         = 1'b0;
    rf_waddr_d      = rf_waddr_q;
    rf_wdata_d      = rf_wdata_q;
    misalign_d      = 1'b0;
    spurious_d      = spurious_q;

    case (state_q)
      IDLE: begin
        // A response with nothing outstanding is flagged only; it never writes.
        if (mem_rvalid) spurious_d = 1'b1;
        if (in_valid) begin
          if (wb_sel == SEL_MEM) begin
            rd_d            = rd;
            reg_write_d     = reg_write;
            load_size_d     = load_size;
            load_unsigned_d = load_unsigned;
            addr_low_d      = addr_low;
            state_d         = WAIT_MEM;
          end else if (reg_write && (rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = select_src(wb_sel);
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (is_misaligned(load_size_q, addr_low_q)) begin
            misalign_d = 1'b1;
          end else if (reg_write_q && (rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = extend_load(mem_rdata, load_size_q, load_unsigned_q, addr_low_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      addr_low_q      <= 2'b00;
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      misalign_q      <= 1'b0;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_q            <= rd_d;
      reg_write_q     <= reg_write_d;
      load_size_q     <= load_size_d;
      load_unsigned_q <= load_unsigned_d;
      addr_low_q      <= addr_low_d;
      rf_we_q         <= rf_we_d;
      rf_waddr_q      <= rf_waddr_d;
      rf_wdata_q      <= rf_wdata_d;
      misalign_q      <= misalign_d;
      spurious_q      <= spurious_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign misalign_err = misalign_q;
  assign spurious_err = spurious_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: source select, load extension, misalign, spurious and reset cases.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] alu_result, pc_plus_4, pc_plus_imm, imm;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic [1:0]  addr_low;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        spurious_err;

  int passed = 0;
  int total  = 0;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd),
    .alu_result(alu_result), .pc_plus_4(pc_plus_4), .pc_plus_imm(pc_plus_imm), .imm(imm),
    .load_size(load_size), .load_unsigned(load_unsigned), .addr_low(addr_low),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_sel = 3'b000; reg_write = 1'b0; rd = '0;
    alu_result = '0; pc_plus_4 = '0; pc_plus_imm = '0; imm = '0;
    load_size = 2'b00; load_unsigned = 1'b0; addr_low = 2'b00;
    mem_rdata = '0; mem_rvalid = 1'b0;
    tick(); tick();
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_spurious", 32'(spurious_err), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(in_ready), 32'h1);

    // ALU op
    in_valid = 1'b1; wb_sel = 3'b000; reg_write = 1'b1; rd = 5'd5; alu_result = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    chk("alu_we", 32'(rf_we), 32'h1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    tick();
    chk("alu_we_drop", 32'(rf_we), 32'h0);
    chk("alu_wdata_hold", rf_wdata, 32'h1234);

    // JAL then AUIPC back to back
    in_valid = 1'b1; wb_sel = 3'b010; rd = 5'd1; pc_plus_4 = 32'h104;
    tick();
    wb_sel = 3'b011; rd = 5'd2; pc_plus_imm = 32'h2100;
    chk("jal_we", 32'(rf_we), 32'h1);
    chk("jal_waddr", 32'(rf_waddr), 32'd1);
    chk("jal_wdata", rf_wdata, 32'h104);
    chk("jal_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("auipc_we", 32'(rf_we), 32'h1);
    chk("auipc_waddr", 32'(rf_waddr), 32'd2);
    chk("auipc_wdata", rf_wdata, 32'h2100);
    tick();
    chk("auipc_we_drop", 32'(rf_we), 32'h0);

    // Signed byte load, addr_low=3
    in_valid = 1'b1; wb_sel = 3'b001; rd = 5'd7; load_size = 2'b00; load_unsigned = 1'b0;
    addr_low = 2'd3; mem_rdata = 32'h80AB_CDEF;
    tick();
    in_valid = 1'b0;
    chk("lb_ready_w1", 32'(in_ready), 32'h0);
    chk("lb_we_w1", 32'(rf_we), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lb_ready_wait", 32'(in_ready), 32'h0);
      chk("lb_we_wait", 32'(rf_we), 32'h0);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("lb_we", 32'(rf_we), 32'h1);
    chk("lb_waddr", 32'(rf_waddr), 32'd7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_ready_back", 32'(in_ready), 32'h1);
    tick();
    chk("lb_we_drop", 32'(rf_we), 32'h0);

    // Unsigned half load, addr_low=2
    in_valid = 1'b1; rd = 5'd8; load_size = 2'b01; load_unsigned = 1'b1;
    addr_low = 2'd2; mem_rdata = 32'h8001_0000;
    tick();
    in_valid = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("lhu_we", 32'(rf_we), 32'h1);
    chk("lhu_waddr", 32'(rf_waddr), 32'd8);
    chk("lhu_wdata", rf_wdata, 32'h0000_8001);
    chk("lhu_misalign", 32'(misalign_err), 32'h0);

    // Misaligned half load, addr_low=1
    in_valid = 1'b1; rd = 5'd9; addr_low = 2'd1;
    tick();
    in_valid = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("mis_err", 32'(misalign_err), 32'h1);
    chk("mis_we", 32'(rf_we), 32'h0);
    chk("mis_wdata_hold", rf_wdata, 32'h0000_8001);
    chk("mis_ready", 32'(in_ready), 32'h1);
    tick();
    chk("mis_err_drop", 32'(misalign_err), 32'h0);

    // LUI to x0 is suppressed, LUI to x3 writes
    in_valid = 1'b1; wb_sel = 3'b100; rd = 5'd0; imm = 32'hDEAD_B000; addr_low = 2'd0;
    tick();
    rd = 5'd3;
    chk("lui_x0_we", 32'(rf_we), 32'h0);
    chk("lui_x0_wdata", rf_wdata, 32'h0000_8001);
    tick();
    in_valid = 1'b0;
    chk("lui_we", 32'(rf_we), 32'h1);
    chk("lui_wdata", rf_wdata, 32'hDEAD_B000);

    // Spurious response in IDLE
    chk("spur_pre", 32'(spurious_err), 32'h0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("spur_set", 32'(spurious_err), 32'h1);
    chk("spur_we", 32'(rf_we), 32'h0);
    tick(); tick();
    chk("spur_sticky", 32'(spurious_err), 32'h1);

    // Reset in WAIT_MEM drops the pending load
    in_valid = 1'b1; wb_sel = 3'b001; rd = 5'd10; load_size = 2'b10; load_unsigned = 1'b0;
    addr_low = 2'd0; mem_rdata = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("rml_ready_wait", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #2;
    chk("rml_spur_clr", 32'(spurious_err), 32'h0);
    chk("rml_ready_rst", 32'(in_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("rml_we", 32'(rf_we), 32'h0);
    chk("rml_spur", 32'(spurious_err), 32'h1);
    tick();
    chk("rml_we_after", 32'(rf_we), 32'h0);
    chk("rml_wdata", rf_wdata, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
